draw_scheduler: RTL and testbench

- Parametrised successor to the two-way bird/wall state alternator in the game control path.
- Arbitrates N drawing sub-controllers (bird, wall, score, background, ...) onto the single datapath state bus feeding the VGA drawing datapath.
- Each client holds its grant for a full draw burst and releases it with a done pulse.
- Adds round-robin or fixed-priority mode, a halt input (collision / game over), and a hold-timeout watchdog.

---
 rtl/draw_scheduler.sv | 119 +++++++++++
 tb/tb_draw_scheduler.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/draw_scheduler.sv
// Arbitrates N drawing sub-controllers onto the shared datapath state bus.
// Each owner keeps the bus for a whole draw burst; a watchdog bounds the hold time.
module draw_scheduler #(
    parameter int                 N_CLIENTS = 2,
    parameter int                 STATE_W   = 4,
    parameter logic [STATE_W-1:0] IDLE_CODE = 4'b1111,
    parameter int                 RR_MODE   = 1,
    parameter int                 MAX_HOLD  = 64
) (
    input  logic                                            clk,
    input  logic                                            resetn,
    input  logic [N_CLIENTS-1:0]                            req,
    input  logic [N_CLIENTS-1:0]                            done,
    input  logic [N_CLIENTS*STATE_W-1:0]                    code,
    input  logic                                            halt,
    output logic [N_CLIENTS-1:0]                            grant,
    output logic                                            busy,
    output logic [((N_CLIENTS > 1) ? $clog2(N_CLIENTS) : 1)-1:0] owner,
    output logic [STATE_W-1:0]                              cur_state,
    output logic                                            timeout
);

    localparam int OW     = (N_CLIENTS > 1) ? $clog2(N_CLIENTS) : 1;
    localparam int HOLD_W = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
    localparam logic [N_CLIENTS-1:0] GRANT_ONE = N_CLIENTS'(1);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } state_t;

    state_t              state;
    logic [HOLD_W-1:0]   hold_cnt;
    logic [OW-1:0]       win;
    logic [STATE_W-1:0]  own_code;
    logic                done_own;
    logic                expire;
    logic                arb_ok;

    // Round-robin starts just past the last owner and checks it last;
    // fixed priority simply takes the lowest requesting index.
    function automatic logic [OW-1:0] pick_winner(input logic [N_CLIENTS-1:0] r,
                                                  input logic [OW-1:0]        last);
        logic [OW-1:0] w;
        logic          found;
        int            idx;
        w     = last;
        found = 1'b0;
        for (int k = 1; k <= N_CLIENTS; k++) begin
            if (RR_MODE != 0) idx = (int'(last) + k) % N_CLIENTS;
            else              idx = k - 1;
            if (!found && r[idx]) begin
                found = 1'b1;
                w     = OW'(idx);
            end
        end
        return w;
    endfunction

    function automatic logic [HOLD_W-1:0] sat_inc(input logic [HOLD_W-1:0] c);
        return (&c) ? c : c + HOLD_W'(1);
    endfunction

    always_comb begin
        win      = pick_winner(req, owner);
        own_code = code[owner*STATE_W +: STATE_W];
        done_own = done[owner];
        expire   = (MAX_HOLD > 0) && (hold_cnt == HOLD_W'(MAX_HOLD - 1));
        arb_ok   = !halt && (|req);
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state     <= S_IDLE;
            grant     <= '0;
            busy      <= 1'b0;
            owner     <= OW'(N_CLIENTS - 1);
            cur_state <= IDLE_CODE;
            timeout   <= 1'b0;
            hold_cnt  <= '0;
        end else begin
            timeout <= 1'b0;
            case (state)
                S_IDLE: begin
                    cur_state <= IDLE_CODE;
                    if (arb_ok) begin
                        state    <= S_BUSY;
                        owner    <= win;
                        grant    <= GRANT_ONE << win;
                        busy     <= 1'b1;
                        hold_cnt <= '0;
                    end
                end
                S_BUSY: begin
                    if (done_own || expire) begin
                        // done takes precedence over an expiring watchdog
                        timeout <= !done_own;
                        if (arb_ok) begin
                            owner     <= win;
                            grant     <= GRANT_ONE << win;
                            hold_cnt  <= '0;
                            cur_state <= own_code;
                        end else begin
                            state     <= S_IDLE;
                            grant     <= '0;
                            busy      <= 1'b0;
                            cur_state <= IDLE_CODE;
                        end
                    end else begin
                        hold_cnt  <= sat_inc(hold_cnt);
                        cur_state <= own_code;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_draw_scheduler.sv
// Drives a round-robin and a fixed-priority scheduler with shared stimulus and
// compares both against a cycle-level reference model of the arbitration rules.
module tb_draw_scheduler;

    localparam int N  = 3;
    localparam int SW = 4;
    localparam int MH = 8;
    localparam logic [SW-1:0] IDLE = 4'b1111;

    logic            clk = 1'b0;
    logic            resetn;
    logic [N-1:0]    req;
    logic [N-1:0]    done;
    logic [N*SW-1:0] code;
    logic            halt;

    logic [N-1:0]  grant_rr, grant_fp;
    logic          busy_rr, busy_fp;
    logic [1:0]    owner_rr, owner_fp;
    logic [SW-1:0] cur_rr, cur_fp;
    logic          to_rr, to_fp;

    int n_checks = 0;
    int n_pass   = 0;

    // reference model state, index 0 = round-robin, 1 = fixed priority
    logic          m_busy [2];
    int            m_owner[2];
    logic [SW-1:0] m_cur  [2];
    logic          m_to   [2];
    int            m_held [2];

    always #5 clk = ~clk;

    draw_scheduler #(.N_CLIENTS(N), .STATE_W(SW), .IDLE_CODE(IDLE), .RR_MODE(1), .MAX_HOLD(MH)) u_rr (
        .clk(clk), .resetn(resetn), .req(req), .done(done), .code(code), .halt(halt),
        .grant(grant_rr), .busy(busy_rr), .owner(owner_rr), .cur_state(cur_rr), .timeout(to_rr)
    );

    draw_scheduler #(.N_CLIENTS(N), .STATE_W(SW), .IDLE_CODE(IDLE), .RR_MODE(0), .MAX_HOLD(MH)) u_fp (
        .clk(clk), .resetn(resetn), .req(req), .done(done), .code(code), .halt(halt),
        .grant(grant_fp), .busy(busy_fp), .owner(owner_fp), .cur_state(cur_fp), .timeout(to_fp)
    );

    function automatic int ref_winner(input bit rr, input logic [N-1:0] r, input int last);
        for (int k = 1; k <= N; k++) begin
            int i = rr ? (last + k) % N : k - 1;
            if (r[i]) return i;
        end
        return last;
    endfunction

    task automatic model_step();
        bit            rel, to_now, arb;
        logic [SW-1:0] nxt;
        for (int m = 0; m < 2; m++) begin
            if (!resetn) begin
                m_busy[m]  = 1'b0;
                m_owner[m] = N - 1;
                m_cur[m]   = IDLE;
                m_to[m]    = 1'b0;
                m_held[m]  = 0;
            end else begin
                rel = 0; to_now = 0; arb = 0;
                nxt = IDLE;
                if (m_busy[m]) begin
                    m_held[m]++;
                    if (done[m_owner[m]]) rel = 1;
                    else if (m_held[m] >= MH) begin rel = 1; to_now = 1; end
                    if (!rel) nxt = code[m_owner[m]*SW +: SW];
                    else if (!halt && req != 0) begin
                        arb = 1;
                        nxt = code[m_owner[m]*SW +: SW];
                    end else m_busy[m] = 1'b0;
                end else if (!halt && req != 0) arb = 1;
                if (arb) begin
                    m_owner[m] = ref_winner(m == 0, req, m_owner[m]);
                    m_busy[m]  = 1'b1;
                    m_held[m]  = 0;
                end
                m_cur[m] = nxt;
                m_to[m]  = to_now;
            end
        end
    endtask

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        assert (got === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    endtask

    task automatic check_one(input int m, input string nm, input logic [N-1:0] g, input logic b,
                             input logic [1:0] o, input logic [SW-1:0] c, input logic t);
        logic [N-1:0] eg;
        eg = m_busy[m] ? (N'(1) << m_owner[m]) : '0;
        chk({nm, "_grant"}, 8'(g), 8'(eg));
        chk({nm, "_busy"}, 8'(b), 8'(m_busy[m]));
        chk({nm, "_owner"}, 8'(o), 8'(m_owner[m]));
        chk({nm, "_cur_state"}, 8'(c), 8'(m_cur[m]));
        chk({nm, "_timeout"}, 8'(t), 8'(m_to[m]));
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        check_one(0, "rr", grant_rr, busy_rr, owner_rr, cur_rr, to_rr);
        check_one(1, "fp", grant_fp, busy_fp, owner_fp, cur_fp, to_fp);
    endtask

    task automatic drive(input logic [N-1:0] r, input logic [N-1:0] d, input logic h);
        req = r; done = d; halt = h;
    endtask

    initial begin
        resetn = 1'b0;
        drive('0, '0, 1'b0);
        code = {4'b1010, 4'b0110, 4'b0011};
        tick(); tick();

        // single grant, code follows one cycle after grant, release on done
        resetn = 1'b1;
        drive(3'b001, '0, 1'b0);
        tick(); tick(); tick();
        drive(3'b000, 3'b001, 1'b0);
        tick();
        drive('0, '0, 1'b0);
        tick();

        // two clients requesting continuously, done after three busy cycles
        for (int b = 0; b < 5; b++) begin
            drive(3'b011, '0, 1'b0);
            tick(); tick();
            drive(3'b011, 3'b111, 1'b0);
            tick();
        end
        drive('0, 3'b111, 1'b0);
        tick();
        drive('0, '0, 1'b0);
        tick();

        // watchdog expiry with no done, then done on the expiry edge
        drive(3'b010, '0, 1'b0);
        tick();
        drive('0, '0, 1'b0);
        repeat (10) tick();
        drive(3'b010, '0, 1'b0);
        tick();
        drive('0, '0, 1'b0);
        repeat (7) tick();
        drive('0, 3'b010, 1'b0);
        tick();
        drive('0, '0, 1'b0);
        repeat (2) tick();

        // halt mid-burst: burst completes, then idle until halt drops
        drive(3'b011, '0, 1'b0);
        tick();
        drive(3'b011, '0, 1'b1);
        tick(); tick();
        drive(3'b011, 3'b111, 1'b1);
        tick();
        drive(3'b011, '0, 1'b1);
        tick(); tick();
        drive(3'b011, '0, 1'b0);
        tick(); tick();
        drive('0, 3'b111, 1'b0);
        tick();

        // reset in the middle of a burst
        code = {4'b1100, 4'b1001, 4'b0101};
        drive(3'b001, '0, 1'b0);
        tick(); tick(); tick();
        resetn = 1'b0;
        tick();
        resetn = 1'b1;
        drive(3'b011, '0, 1'b0);
        tick(); tick();
        drive('0, 3'b111, 1'b0);
        tick();

        // randomized traffic
        for (int i = 0; i < 600; i++) begin
            resetn = ($urandom_range(0, 79) != 0);
            req    = N'($urandom_range(0, 7));
            halt   = ($urandom_range(0, 7) == 0);
            done   = ($urandom_range(0, 3) == 0) ? N'($urandom_range(0, 7)) : '0;
            code   = (N*SW)'($urandom);
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
